// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   PC_STEP       : byte distance between consecutive instructions
//   fetch_entry_t : default fetch-buffer entry {instr, pc}
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  localparam int unsigned PC_STEP       = 4;
  localparam int unsigned FETCH_ADDRSZ  = 64;
  localparam int unsigned FETCH_INSTRSZ = 32;

  typedef struct packed {
    logic [FETCH_INSTRSZ-1:0] instr;
    logic [FETCH_ADDRSZ-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched words with their PCs.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, push_data  : write an entry (ignored while flushing)
//   pop              : remove the head entry (ignored when empty or flushing)
//   flush            : discard all entries; wins over push and pop
//   head             : current head entry (all zero after reset)
//   count/full/empty : occupancy
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Holds the PC, issues one-at-a-time word reads to instruction memory, buffers
// returned words with their PCs and hands them to the decoder via valid/ready.
// A redirect flushes the buffer and restarts fetch at the new (word-aligned) PC.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   mem_req_valid/ready/addr       : read request channel (one outstanding max)
//   mem_resp_valid/data            : single-cycle read response, no backpressure
//   redirect_valid/pc              : restart fetch at redirect_pc (bits [1:0] cleared)
//   instr_valid/ready, instr/pc    : instruction channel to the decoder
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDRSZ     = 64,
  parameter int unsigned       INSTRSZ    = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDRSZ-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDRSZ-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [INSTRSZ-1:0] mem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDRSZ-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTRSZ-1:0] instr,
  output logic [ADDRSZ-1:0]  instr_pc
);

  typedef struct packed {
    logic [INSTRSZ-1:0] instr;
    logic [ADDRSZ-1:0]  pc;
  } entry_t;

  localparam int unsigned    CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FIFO_DEPTH - 1);
  localparam logic [ADDRSZ-1:0] STEP  = ADDRSZ'(PC_STEP);

  fetch_state_e      state, state_nxt;
  logic [ADDRSZ-1:0] pc, pc_nxt;
  // stale: a redirect hit a request that memory has not yet accepted. The
  // request keeps its old address (stale_addr) while pc already holds the
  // redirect target; the response to that request will be discarded.
  logic              stale, stale_nxt;
  logic [ADDRSZ-1:0] stale_addr, stale_addr_nxt;
  logic [ADDRSZ-1:0] redir_pc;
  logic              req_fire;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  assign redir_pc      = redirect_pc & ~ADDRSZ'(3);
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = stale ? stale_addr : pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign instr_valid   = !empty;
  assign instr         = head.instr;
  assign instr_pc      = head.pc;
  assign pop           = instr_valid && instr_ready;

  // In WAIT without a redirect, pc has already advanced past the word in flight.
  assign push          = (state == WAIT) && mem_resp_valid && !redirect_valid;
  assign push_data     = '{instr: mem_resp_data, pc: pc - STEP};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    stale_nxt      = stale;
    stale_addr_nxt = stale_addr;
    unique case (state)
      IDLE: begin
        // Nothing is outstanding here, so credit reduces to a free slot.
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = REQ;
        end else if (!full) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (req_fire) begin
          stale_nxt = 1'b0;
          if (redirect_valid || stale) begin
            state_nxt = DROP;
            if (redirect_valid) pc_nxt = redir_pc;
          end else begin
            state_nxt = WAIT;
            pc_nxt    = pc + STEP;
          end
        end else if (redirect_valid) begin
          if (!stale) begin
            stale_nxt      = 1'b1;
            stale_addr_nxt = pc;
          end
          pc_nxt = redir_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = mem_resp_valid ? REQ : DROP;
        end else if (mem_resp_valid) begin
          // Credit after this push: count + 1 < FIFO_DEPTH.
          state_nxt = (count < CNT_LAST) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) pc_nxt = redir_pc;
        if (mem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale      <= 1'b0;
      stale_addr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      stale      <= stale_nxt;
      stale_addr <= stale_addr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a transaction-level
// reference model (expected buffer contents as a queue, expected fetch address
// as architectural PC arithmetic) checked every cycle, plus literal checks.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] i;
    logic [63:0] p;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  fetch_unit #(
    .ADDRSZ     (64),
    .INSTRSZ    (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (64'h0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat = 1;
  logic        data_mode = 1'b0;
  logic        mf_seen = 1'b0;
  logic [63:0] mf_addr = 64'h0;
  logic        mp = 1'b0;
  int          mw = 0;
  logic [63:0] ma = 64'h0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return data_mode ? (32'hC0DE_0000 | {16'h0, a[15:0]}) : 32'h0000_0013;
  endfunction

  always @(negedge clk) begin
    mf_seen = mem_req_valid && mem_req_ready;
    mf_addr = mem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    if (mf_seen) begin
      mp = 1'b1;
      mw = mem_lat;
      ma = mf_addr;
    end
    if (mp) begin
      mw--;
      if (mw == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = word_of(ma);
        mp = 1'b0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  ent_t        mq[$];
  logic [63:0] m_pc = 64'h0;
  logic        m_inf = 1'b0;
  logic        m_inf_drop = 1'b0;
  logic [63:0] m_inf_addr = 64'h0;
  logic        drop_next = 1'b0;
  logic        held = 1'b0;
  logic [63:0] held_addr = 64'h0;
  logic [63:0] exp_a;
  logic        fire;
  ent_t        e;

  always @(negedge clk) begin
    if (!reset_n) begin
      chkb("rst_instr_valid", instr_valid, 1'b0);
      chkb("rst_req_valid", mem_req_valid, 1'b0);
      chk("rst_req_addr", mem_req_addr, 64'h0);
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_instr_pc", instr_pc, 64'h0);
      mq.delete();
      m_pc = 64'h0; m_inf = 1'b0; m_inf_drop = 1'b0; drop_next = 1'b0;
      held = 1'b0; held_addr = 64'h0;
    end else begin
      chkb("m_instr_valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0 && instr_valid) begin
        chk("m_instr", 64'(instr), 64'(mq[0].i));
        chk("m_instr_pc", instr_pc, mq[0].p);
      end
      exp_a = held ? held_addr : m_pc;
      if (held) chkb("m_req_hold", mem_req_valid, 1'b1);
      if (mem_req_valid) begin
        chk("m_req_addr", mem_req_addr, exp_a);
        chkb("m_req_credit", (mq.size() < DEPTH) && !m_inf, 1'b1);
      end
      fire = mem_req_valid && mem_req_ready;
      // buffer update: a redirect discards everything, including a same-cycle response
      if (redirect_valid) begin
        mq.delete();
      end else begin
        if (instr_ready && mq.size() != 0) void'(mq.pop_front());
        if (mem_resp_valid && m_inf && !m_inf_drop) begin
          e.i = mem_resp_data;
          e.p = m_inf_addr;
          mq.push_back(e);
        end
      end
      if (mem_resp_valid) m_inf = 1'b0;
      else if (redirect_valid && m_inf) m_inf_drop = 1'b1;
      if (fire) begin
        m_inf      = 1'b1;
        m_inf_addr = exp_a;
        m_inf_drop = redirect_valid || drop_next;
        if (!m_inf_drop) m_pc = exp_a + 64'd4;
        drop_next  = 1'b0;
      end else if (mem_req_valid && redirect_valid) begin
        drop_next = 1'b1;
      end
      if (redirect_valid) m_pc = redirect_pc & ~64'h3;
      held      = mem_req_valid && !mem_req_ready;
      held_addr = exp_a;
    end
  end

  // ---------------- stimulus ----------------
  task automatic at_neg(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic at_drv(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int lat, input logic rdy, input logic irdy, input logic dm);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    mem_req_ready = rdy;
    instr_ready = irdy;
    mem_lat = lat;
    data_mode = dm;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    // T1: 1-cycle memory, constant NOP word, decoder always ready
    do_reset(1, 1'b1, 1'b1, 1'b0);
    at_neg(1); chkb("t1_req_valid", mem_req_valid, 1'b1); chk("t1_req_addr", mem_req_addr, 64'h0);
    at_neg(2); chkb("t1_no_early_valid", instr_valid, 1'b0);
    at_neg(3); chkb("t1_valid0", instr_valid, 1'b1); chk("t1_pc0", instr_pc, 64'h0);
    chk("t1_instr0", 64'(instr), 64'h13);
    at_neg(5); chk("t1_pc4", instr_pc, 64'h4);
    at_neg(7); chk("t1_pc8", instr_pc, 64'h8);
    at_neg(8); chkb("t1_gap", instr_valid, 1'b0);

    // T2: decoder stalled, buffer fills to exactly DEPTH
    do_reset(1, 1'b1, 1'b0, 1'b1);
    for (int k = 9; k <= 19; k++) begin
      at_neg(k); chkb("t2_no_req_when_full", mem_req_valid, 1'b0);
    end
    chkb("t2_valid", instr_valid, 1'b1); chk("t2_head_pc", instr_pc, 64'h0);
    at_drv(20); instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg(20 + k); chk("t2_drain_pc", instr_pc, 64'(4 * k));
    end
    at_neg(24); chk("t2_refill_pc", instr_pc, 64'h10); chk("t2_refill_instr", 64'(instr), 64'hC0DE0010);

    // T3: redirect in WAIT, response two cycles later is dropped
    do_reset(3, 1'b1, 1'b1, 1'b1);
    at_neg(9); chkb("t3_req8_valid", mem_req_valid, 1'b1); chk("t3_req8_addr", mem_req_addr, 64'h8);
    at_drv(10); redirect_valid = 1'b1; redirect_pc = 64'h1000;
    at_drv(11); redirect_valid = 1'b0;
    at_neg(12); chkb("t3_drop_no_req", mem_req_valid, 1'b0);
    at_neg(13); chk("t3_new_addr", mem_req_addr, 64'h1000); chkb("t3_empty", instr_valid, 1'b0);
    at_neg(17); chkb("t3_valid", instr_valid, 1'b1); chk("t3_pc", instr_pc, 64'h1000);

    // T4: redirect with same-cycle response, misaligned target
    do_reset(1, 1'b1, 1'b1, 1'b1);
    at_drv(2); redirect_valid = 1'b1; redirect_pc = 64'h2003;
    at_drv(3); redirect_valid = 1'b0;
    at_neg(3); chkb("t4_req_valid", mem_req_valid, 1'b1); chk("t4_addr", mem_req_addr, 64'h2000);
    chkb("t4_discarded", instr_valid, 1'b0);
    at_neg(5); chk("t4_pc", instr_pc, 64'h2000);

    // T5: redirect while request pending and not accepted
    do_reset(1, 1'b0, 1'b1, 1'b1);
    at_drv(2); redirect_valid = 1'b1; redirect_pc = 64'h3000;
    at_drv(3); redirect_valid = 1'b0;
    at_neg(3); chkb("t5_hold_valid", mem_req_valid, 1'b1); chk("t5_hold_addr", mem_req_addr, 64'h0);
    at_drv(6); mem_req_ready = 1'b1;
    at_neg(6); chk("t5_accept_addr", mem_req_addr, 64'h0);
    at_neg(7); chkb("t5_drop_no_req", mem_req_valid, 1'b0); chkb("t5_dropped", instr_valid, 1'b0);
    at_neg(8); chkb("t5_req_valid", mem_req_valid, 1'b1); chk("t5_new_addr", mem_req_addr, 64'h3000);
    at_neg(10); chkb("t5_valid", instr_valid, 1'b1); chk("t5_pc", instr_pc, 64'h3000);

    // T6: asynchronous reset mid-WAIT with a buffered word, stale response afterwards
    do_reset(3, 1'b1, 1'b0, 1'b1);
    at_neg(6); chkb("t6_buffered", instr_valid, 1'b1); chkb("t6_in_wait", mem_req_valid, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chkb("t6_async_instr_valid", instr_valid, 1'b0);
    chkb("t6_async_req_valid", mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1; cyc = 0; instr_ready = 1'b1;
    at_neg(1); chkb("t6_restart_valid", mem_req_valid, 1'b1); chk("t6_restart_addr", mem_req_addr, 64'h0);
    for (int k = 2; k <= 4; k++) begin
      at_neg(k); chkb("t6_stale_not_pushed", instr_valid, 1'b0);
    end
    at_neg(5); chkb("t6_valid", instr_valid, 1'b1); chk("t6_pc", instr_pc, 64'h0);
    chk("t6_instr", 64'(instr), 64'hC0DE0000);

    // T7: PC wraps past the top of the address space
    do_reset(1, 1'b1, 1'b1, 1'b1);
    at_drv(2); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    at_drv(3); redirect_valid = 1'b0;
    at_neg(3); chk("t7_top_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    at_neg(5); chk("t7_wrap_addr", mem_req_addr, 64'h0);
    chk("t7_top_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    at_neg(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
